// File: rtl/imm_encoder_loader.sv
// Immediate encoder and program loader: packs RV32I fields plus a range-checked
// immediate into instruction words and streams them to consecutive word addresses.
module imm_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      imm,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      addr_nxt;
    logic [31:0]      word;
    logic             imm_ok;
    logic             in_fire;
    logic             out_fire;

    // Signed range checks reduce to "upper bits are a pure sign extension".
    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        case (ImmSrc)
            3'b000: begin
                word   = {imm[11:0], rs1, funct3, rd, opcode};
                imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            3'b001: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            3'b010: begin
                word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            end
            3'b011: begin
                word   = {imm[31:12], rd, opcode};
                imm_ok = ~(|imm[11:0]);
            end
            3'b100: begin
                word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                imm_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            end
            default: begin
                word   = {funct7, rs2, rs1, funct3, rd, opcode};
                imm_ok = 1'b1;
            end
        endcase
    end

    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);
    assign in_ready = busy && (cnt < len_q) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // A word loaded in the same cycle the previous one drains lands at the next slot.
    assign addr_nxt = addr_q + (out_fire ? 32'd4 : 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            addr_q    <= BASE_ADDR;
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR;
            out_data  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            addr_q <= addr_nxt;
            if (in_fire) begin
                cnt <= cnt + LEN_W'(1);
                if (!imm_ok) begin
                    err <= 1'b1;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + LEN_W'(1);
                    if (out_fire)
                        out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= word;
                    out_addr  <= addr_nxt;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        len_q   <= len;
                        cnt     <= '0;
                        err     <= 1'b0;
                        err_cnt <= '0;
                        addr_q  <= BASE_ADDR;
                    end
                end
                S_LOAD: begin
                    if (cnt == len_q && !out_valid)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Scoreboard bench for imm_encoder_loader: expected {addr,data} queued at drive
// time, popped by a monitor whenever the DUT hands a word to memory.
module tb_imm_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [15:0] len;
    logic        in_ready, out_valid, busy, done, err;
    logic [2:0]  ImmSrc, funct3;
    logic [31:0] imm, out_addr, out_data;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    imm_encoder_loader #(.BASE_ADDR(32'h0000_0000), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .ImmSrc(ImmSrc), .imm(imm),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [63:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_word unexpected: got addr=%h data=%h, none expected", out_addr, out_data);
            end else begin
                e = sb.pop_front();
                if ({out_addr, out_data} !== e) begin
                    errors++;
                    $display("FAIL out_word: got addr=%h data=%h, want addr=%h data=%h",
                             out_addr, out_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input logic [2:0] src, input logic [31:0] im, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7, output int waits);
        ImmSrc = src; imm = im; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, want 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_timeout: got done=0, want 1", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
        ImmSrc = '0; imm = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 00000", {in_ready, out_valid, busy, done, err});
        end
        checks++;
        if (out_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h, want 00000000", out_addr);
        end
        checks++;
        if (out_data !== 32'h0 || err_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_data_errcnt: got %h/%h, want 0/0", out_data, err_cnt);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        int w;
        out_ready = 1'b1;
        pulse_start(16'd5);
        sb.push_back({32'h0,  32'h00F00093});
        sb.push_back({32'h4,  32'h00512523});
        sb.push_back({32'h8,  32'h00208463});
        sb.push_back({32'hC,  32'h12345037});
        sb.push_back({32'h10, 32'h0FA0006F});
        drive(3'b000, 32'd15,        7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, w);
        drive(3'b001, 32'd10,        7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, w);
        drive(3'b010, 32'd8,         7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, w);
        drive(3'b011, 32'h12345000,  7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, w);
        drive(3'b100, 32'h000000FA,  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, w);
        wait_done("formats");
        checks++;
        if (err !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL formats_end: got err=%b pending=%0d, want 0/0", err, sb.size());
        end
    endtask

    task automatic test_rejects();
        int w;
        pulse_start(16'd3);
        sb.push_back({32'h0, 32'h8000006F});
        drive(3'b010, 32'd7,         7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, w);
        drive(3'b000, 32'd2048,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, w);
        drive(3'b100, 32'hFFF00000,  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, w);
        wait_done("rejects");
        checks++;
        if (err !== 1'b1 || err_cnt !== 16'd2) begin
            errors++; $display("FAIL rejects_err: got err=%b cnt=%0d, want 1/2", err, err_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rejects_pending: got %0d words missing, want 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] exp0;
        exp0 = 32'h00100093;
        out_ready = 1'b0;
        pulse_start(16'd4);
        sb.push_back({32'h0, exp0});
        sb.push_back({32'h4, 32'h00200113});
        sb.push_back({32'h8, 32'h00300193});
        sb.push_back({32'hC, 32'h00400213});
        drive(3'b000, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, w);
        ImmSrc = 3'b000; imm = 32'd2; rd = 5'd2; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_addr, out_data} !== {32'h0, exp0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b vld=%b addr=%h data=%h, want 0/1/0/%h",
                         i, in_ready, out_valid, out_addr, out_data, exp0);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(3'b000, 32'd3, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, w);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL bp_thru3: got %0d stall cycles, want 0", w);
        end
        drive(3'b000, 32'd4, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, w);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL bp_thru4: got %0d stall cycles, want 0", w);
        end
        wait_done("backpressure");
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL bp_pending: got %0d words missing, want 0", sb.size());
        end
    endtask

    task automatic test_start_in_load();
        int w;
        out_ready = 1'b1;
        pulse_start(16'd3);
        sb.push_back({32'h0, 32'h402081B3});
        sb.push_back({32'h4, 32'hFFFFF297});
        sb.push_back({32'h8, 32'hFE112FA3});
        drive(3'b101, 32'hDEADBEEF, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, w);
        pulse_start(16'd7);
        checks++;
        if (busy !== 1'b1 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL start_ignored: got busy=%b cnt=%0d, want 1/0", busy, err_cnt);
        end
        drive(3'b011, 32'hFFFFF000, 7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, w);
        drive(3'b001, 32'hFFFFFFFF, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, w);
        wait_done("start_in_load");
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL start_pending: got %0d words missing, want 0", sb.size());
        end
        pulse_start(16'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL len0_load: got busy=%b, want 1", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL len0_done: got done=%b, want 1", done);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        pulse_start(16'd3);
        sb.push_back({32'h0, 32'h00F00093});
        drive(3'b010, 32'd1,  7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, w);
        drive(3'b000, 32'd15, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, w);
        checks++;
        if (out_valid !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got vld=%b err=%b, want 1/1", out_valid, err);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, err, done, in_ready} !== 5'b0 || out_addr !== 32'h0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b addr=%h cnt=%0d, want 0/0/0",
                     {out_valid, busy, err, done, in_ready}, out_addr, err_cnt);
        end
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        pulse_start(16'd1);
        sb.push_back({32'h0, 32'hFFF00113});
        drive(3'b000, 32'hFFFFFFFF, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, w);
        wait_done("reset_mid");
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL mid_restart_pending: got %0d words missing, want 0", sb.size());
        end
    endtask

    task automatic test_err_saturate();
        out_ready = 1'b1;
        pulse_start(16'hFFFF);
        ImmSrc = 3'b010; imm = 32'd1; opcode = 7'h63; in_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err_cnt !== 16'hFFFF || err !== 1'b1) begin
            errors++; $display("FAIL err_sat: got cnt=%h err=%b, want FFFF/1", err_cnt, err);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL err_sat_done: got done=%b, want 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_rejects();
        test_backpressure();
        test_start_in_load();
        test_reset_mid();
        test_err_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
